// File: rtl/game_pkg.sv
// Shared types for the falling-block game flow: board command codes, sequencer
// states and the pending-action bundle.
package game_pkg;

    localparam int ROWS_DEF = 20;
    localparam int COLS_DEF = 10;

    typedef enum logic [3:0] {
        CMD_NONE  = 4'd0,
        CMD_WIPE  = 4'd1,
        CMD_SPAWN = 4'd2,
        CMD_LEFT  = 4'd3,
        CMD_RIGHT = 4'd4,
        CMD_ROT_L = 4'd5,
        CMD_ROT_R = 4'd6,
        CMD_FALL  = 4'd7,
        CMD_HOLD  = 4'd8,
        CMD_PLACE = 4'd9,
        CMD_CLEAR = 4'd10
    } cmd_e;

    typedef enum logic [3:0] {
        S_WIPE,
        S_LOGO,
        S_LOAD,
        S_IDLE,
        S_ACT,
        S_PLACE,
        S_SCAN,
        S_CLEAR,
        S_END
    } state_e;

    // One bit per queued action, listed in service priority order
    typedef struct packed {
        logic hold;
        logic rot_r;
        logic rot_l;
        logic left;
        logic right;
        logic fall;
    } pend_t;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/game_flow_sequencer_tick_divider.sv
// Frame-tick divider: counts enabled ticks, pulses expire on the tick that reaches period-1.
// expire is combinational in the same cycle as that tick; clear has priority over counting.
module tick_divider #(
    parameter int W = 5
) (
    input  logic         Clk,
    input  logic         RESET,
    input  logic         tick,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] period,
    output logic         expire
);

    logic [W-1:0] count;

    assign expire = tick && enable && (count >= period - W'(1));

    always_ff @(posedge Clk) begin
        if (RESET || clear) begin
            count <= '0;
        end else if (tick && enable) begin
            count <= expire ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/game_flow_sequencer.sv
// Game-flow sequencer: one board command at a time over cmd_valid/board_done, piece lifecycle.
// Commands issue one cycle after the deciding event; cmd_valid drops for at least one cycle between commands.
module game_flow_sequencer
    import game_pkg::*;
#(
    parameter int ROWS            = ROWS_DEF,
    parameter int GRAVITY_TICKS   = 30,
    parameter int SOFT_DROP_TICKS = 2,
    parameter int LOCK_TICKS      = 15,
    parameter int HOLD_EN         = 1,
    parameter int LINE_W          = 16
) (
    input  logic                    Clk,
    input  logic                    RESET,
    input  logic                    start,
    input  logic                    tick,
    input  logic                    key_left,
    input  logic                    key_right,
    input  logic                    key_rot_l,
    input  logic                    key_rot_r,
    input  logic                    key_hold,
    input  logic                    soft_drop,
    input  logic                    board_done,
    input  logic                    board_ok,
    input  logic                    row_full,
    output cmd_e                    cmd,
    output logic                    cmd_valid,
    output logic [$clog2(ROWS)-1:0] scan_row,
    output logic [LINE_W-1:0]       lines_cleared,
    output logic [2:0]              lock_lines,
    output logic                    lock_strobe,
    output logic                    game_over
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int GMAX  = (GRAVITY_TICKS > SOFT_DROP_TICKS) ? GRAVITY_TICKS : SOFT_DROP_TICKS;
    localparam int CMAX  = (GMAX > LOCK_TICKS) ? GMAX : LOCK_TICKS;
    localparam int CNT_W = $clog2(CMAX + 1);

    state_e state;
    pend_t  pend;
    pend_t  pend_nxt;
    pend_t  key_in;
    pend_t  svc;
    cmd_e   sel_cmd;
    logic   grounded;
    logic   hold_used;
    logic   keys_open;
    logic   spawn_ok;
    logic   lock_clr;
    logic   grav_exp;
    logic   lock_exp;
    logic [CNT_W-1:0] grav_period;

    assign keys_open   = !(state inside {S_WIPE, S_LOGO, S_END});
    assign spawn_ok    = (state == S_LOAD) && board_done && board_ok;
    assign grav_period = soft_drop ? CNT_W'(SOFT_DROP_TICKS) : CNT_W'(GRAVITY_TICKS);

    // Lock delay restarts whenever a successful move or hold lifts the piece off the stack
    assign lock_clr = spawn_ok
                   || ((state == S_ACT) && board_done && board_ok
                       && (cmd inside {CMD_LEFT, CMD_RIGHT, CMD_ROT_L, CMD_ROT_R, CMD_HOLD}));

    tick_divider #(.W(CNT_W)) u_gravity (
        .Clk    (Clk),
        .RESET  (RESET),
        .tick   (tick),
        .enable (state == S_IDLE),
        .clear  (spawn_ok),
        .period (grav_period),
        .expire (grav_exp)
    );

    tick_divider #(.W(CNT_W)) u_lock (
        .Clk    (Clk),
        .RESET  (RESET),
        .tick   (tick),
        .enable ((state == S_IDLE) && grounded),
        .clear  (lock_clr),
        .period (CNT_W'(LOCK_TICKS)),
        .expire (lock_exp)
    );

    always_comb begin
        key_in       = '0;
        key_in.hold  = key_hold && (HOLD_EN != 0);
        key_in.rot_r = key_rot_r;
        key_in.rot_l = key_rot_l;
        key_in.left  = key_left;
        key_in.right = key_right;
    end

    // A pending hold is always consumed; it only becomes a command when still allowed
    always_comb begin
        sel_cmd = CMD_NONE;
        svc     = '0;
        svc.hold = pend.hold;
        if (pend.hold && (HOLD_EN != 0) && !hold_used) begin
            sel_cmd = CMD_HOLD;
        end else if (pend.rot_r) begin
            sel_cmd   = CMD_ROT_R;
            svc.rot_r = 1'b1;
        end else if (pend.rot_l) begin
            sel_cmd   = CMD_ROT_L;
            svc.rot_l = 1'b1;
        end else if (pend.left) begin
            sel_cmd  = CMD_LEFT;
            svc.left = 1'b1;
        end else if (pend.right) begin
            sel_cmd   = CMD_RIGHT;
            svc.right = 1'b1;
        end else if (pend.fall) begin
            sel_cmd  = CMD_FALL;
            svc.fall = 1'b1;
        end
    end

    always_comb begin
        pend_nxt = pend;
        if (state == S_IDLE) begin
            if (lock_exp) begin
                pend_nxt.fall = 1'b0;
            end else begin
                pend_nxt = pend_t'(pend & ~svc);
                if (grav_exp) pend_nxt.fall = 1'b1;
            end
        end
        if (keys_open) pend_nxt = pend_t'(pend_nxt | key_in);
        if ((state == S_LOAD) && board_done && !board_ok) pend_nxt = '0;
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state         <= S_WIPE;
            pend          <= '0;
            grounded      <= 1'b0;
            hold_used     <= 1'b0;
            lines_cleared <= '0;
            scan_row      <= '0;
            lock_lines    <= '0;
            cmd           <= CMD_WIPE;
            cmd_valid     <= 1'b0;
            lock_strobe   <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            pend        <= pend_nxt;
            lock_strobe <= 1'b0;
            case (state)
                S_WIPE: begin
                    if (!cmd_valid) begin
                        cmd       <= CMD_WIPE;
                        cmd_valid <= 1'b1;
                    end else if (board_done) begin
                        cmd_valid <= 1'b0;
                        state     <= S_LOGO;
                    end
                end
                S_LOGO: begin
                    if (start) begin
                        cmd       <= CMD_SPAWN;
                        cmd_valid <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (board_done) begin
                        cmd_valid <= 1'b0;
                        if (board_ok) begin
                            state <= S_IDLE;
                        end else begin
                            state     <= S_END;
                            game_over <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (lock_exp) begin
                        cmd       <= CMD_PLACE;
                        cmd_valid <= 1'b1;
                        state     <= S_PLACE;
                    end else if (sel_cmd != CMD_NONE) begin
                        cmd       <= sel_cmd;
                        cmd_valid <= 1'b1;
                        state     <= S_ACT;
                    end
                end
                S_ACT: begin
                    if (board_done) begin
                        cmd_valid <= 1'b0;
                        state     <= S_IDLE;
                        case (cmd)
                            CMD_FALL: begin
                                if (!board_ok) grounded <= 1'b1;
                            end
                            CMD_LEFT, CMD_RIGHT, CMD_ROT_L, CMD_ROT_R: begin
                                if (board_ok) grounded <= 1'b0;
                            end
                            CMD_HOLD: begin
                                if (board_ok) begin
                                    hold_used <= 1'b1;
                                    grounded  <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_PLACE: begin
                    if (board_done) begin
                        cmd_valid  <= 1'b0;
                        scan_row   <= ROW_W'(ROWS - 1);
                        lock_lines <= '0;
                        state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (row_full) begin
                        cmd       <= CMD_CLEAR;
                        cmd_valid <= 1'b1;
                        state     <= S_CLEAR;
                    end else if (scan_row == '0) begin
                        lock_strobe <= 1'b1;
                        hold_used   <= 1'b0;
                        grounded    <= 1'b0;
                        cmd         <= CMD_SPAWN;
                        cmd_valid   <= 1'b1;
                        state       <= S_LOAD;
                    end else begin
                        scan_row <= scan_row - ROW_W'(1);
                    end
                end
                S_CLEAR: begin
                    // Rows above drop into the cleared one, so the same row is rescanned
                    if (board_done) begin
                        cmd_valid  <= 1'b0;
                        lock_lines <= sat_inc3(lock_lines);
                        if (lines_cleared != {LINE_W{1'b1}}) begin
                            lines_cleared <= lines_cleared + LINE_W'(1);
                        end
                        state <= S_SCAN;
                    end
                end
                S_END: begin
                    if (start) begin
                        game_over <= 1'b0;
                        cmd       <= CMD_WIPE;
                        state     <= S_WIPE;
                    end
                end
                default: state <= S_WIPE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Scoreboard bench: expected board commands are queued with stimulus, a board responder checks and answers them.
module tb_game_flow_sequencer;
    import game_pkg::*;

    logic        Clk = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic        key_left = 1'b0;
    logic        key_right = 1'b0;
    logic        key_rot_l = 1'b0;
    logic        key_rot_r = 1'b0;
    logic        key_hold = 1'b0;
    logic        soft_drop = 1'b0;
    logic        board_done = 1'b0;
    logic        board_ok = 1'b0;
    logic        row_full;
    cmd_e        cmd;
    logic        cmd_valid;
    logic [4:0]  scan_row;
    logic [15:0] lines_cleared;
    logic [2:0]  lock_lines;
    logic        lock_strobe;
    logic        game_over;

    typedef struct {
        cmd_e cmd;
        int   row;
        logic ok;
        int   dly;
        logic stray;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cmds_seen = 0;
    logic busy = 1'b0;
    int   full_left = 0;
    int   strobe_cnt = 0;
    logic [2:0] strobe_lines = '0;
    int   base;

    game_flow_sequencer dut (
        .Clk           (Clk),
        .RESET         (RESET),
        .start         (start),
        .tick          (tick),
        .key_left      (key_left),
        .key_right     (key_right),
        .key_rot_l     (key_rot_l),
        .key_rot_r     (key_rot_r),
        .key_hold      (key_hold),
        .soft_drop     (soft_drop),
        .board_done    (board_done),
        .board_ok      (board_ok),
        .row_full      (row_full),
        .cmd           (cmd),
        .cmd_valid     (cmd_valid),
        .scan_row      (scan_row),
        .lines_cleared (lines_cleared),
        .lock_lines    (lock_lines),
        .lock_strobe   (lock_strobe),
        .game_over     (game_over)
    );

    always #5 Clk = ~Clk;

    // Board model: the bottom row reads full until full_left clears have happened
    assign row_full = (scan_row == 5'd19) && (full_left > 0);

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input cmd_e c, input int row, input logic ok, input int dly, input logic stray);
        exp_t e;
        e.cmd = c; e.row = row; e.ok = ok; e.dly = dly; e.stray = stray;
        exp_q.push_back(e);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1 tick = 1'b1;
            @(posedge Clk); #1 tick = 1'b0;
        end
    endtask

    task automatic press(input logic [4:0] m);
        @(posedge Clk); #1 {key_hold, key_rot_r, key_rot_l, key_left, key_right} = m;
        @(posedge Clk); #1 {key_hold, key_rot_r, key_rot_l, key_left, key_right} = '0;
    endtask

    task automatic pulse_start();
        @(posedge Clk); #1 start = 1'b1;
        @(posedge Clk); #1 start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) @(negedge Clk);
        check_val(tag, exp_q.size() + int'(busy), 0);
    endtask

    task automatic wait_q_empty(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge Clk);
        check_val(tag, exp_q.size(), 0);
    endtask

    // Board responder: each new command pops the scoreboard, then answers after e.dly cycles
    initial begin : responder
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge Clk);
            if (RESET || !cmd_valid) begin
                prev_v = 1'b0;
            end else if (!prev_v) begin
                prev_v = 1'b1;
                busy = 1'b1;
                cmds_seen++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_cmd", cmd, CMD_NONE);
                    e.cmd = cmd; e.row = 0; e.ok = 1'b1; e.dly = 1; e.stray = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    check_val("cmd_order", cmd, e.cmd);
                    if (e.cmd == CMD_CLEAR) check_val("clear_row", scan_row, e.row);
                end
                if (e.stray) begin
                    for (int i = 0; i < 100 && !RESET; i++) @(negedge Clk);
                    for (int i = 0; i < 100 && RESET; i++) @(negedge Clk);
                    board_done = 1'b1; board_ok = 1'b1;
                    @(posedge Clk); #1 board_done = 1'b0; board_ok = 1'b0;
                end else begin
                    repeat (e.dly) @(posedge Clk);
                    #1;
                    check_val("valid_held", cmd_valid, 1);
                    check_val("cmd_stable", cmd, e.cmd);
                    board_done = 1'b1; board_ok = e.ok;
                    if (e.cmd == CMD_CLEAR && full_left > 0) full_left--;
                    @(posedge Clk); #1 board_done = 1'b0; board_ok = 1'b0;
                    check_val("valid_drop", cmd_valid, 0);
                end
                prev_v = 1'b0;
                busy = 1'b0;
            end
        end
    end

    initial begin : strobe_mon
        forever begin
            @(negedge Clk);
            if (lock_strobe) begin
                strobe_cnt++;
                strobe_lines = lock_lines;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_val("rst_valid", cmd_valid, 0);
        check_val("rst_game_over", game_over, 0);
        check_val("rst_lines", lines_cleared, 0);
        check_val("rst_strobe", lock_strobe, 0);
        check_val("rst_scan_row", scan_row, 0);
        check_val("rst_lock_lines", lock_lines, 0);

        // Wipe, title wait, blocked spawn ends the game
        push(CMD_WIPE, 0, 1'b1, 3, 1'b0);
        @(posedge Clk); #1 RESET = 1'b0;
        wait_drain("wipe");
        repeat (5) @(negedge Clk);
        check_val("logo_waits", cmd_valid, 0);
        push(CMD_SPAWN, 0, 1'b0, 2, 1'b0);
        pulse_start();
        wait_drain("spawn_blocked");
        check_val("game_over", game_over, 1);
        press(5'b00010);
        push(CMD_WIPE, 0, 1'b1, 2, 1'b0);
        pulse_start();
        wait_drain("rewipe");
        push(CMD_SPAWN, 0, 1'b1, 2, 1'b0);
        pulse_start();
        wait_drain("spawn_ok");
        check_val("game_resumed", game_over, 0);

        // Hold outranks left; a second hold on the same piece is dropped
        push(CMD_HOLD, 0, 1'b1, 2, 1'b0);
        push(CMD_LEFT, 0, 1'b1, 2, 1'b0);
        press(5'b10010);
        wait_drain("hold_left");
        base = cmds_seen;
        press(5'b10000);
        repeat (10) @(negedge Clk);
        check_val("hold_reuse_blocked", cmds_seen, base);

        // Gravity: fall on the 30th tick, then every 2nd tick under soft drop
        base = cmds_seen;
        tick_n(29);
        repeat (3) @(negedge Clk);
        check_val("no_fall_29", cmds_seen, base);
        push(CMD_FALL, 0, 1'b1, 2, 1'b0);
        tick_n(1);
        wait_drain("fall_30");
        soft_drop = 1'b1;
        base = cmds_seen;
        tick_n(1);
        repeat (3) @(negedge Clk);
        check_val("soft_no_fall_1", cmds_seen, base);
        push(CMD_FALL, 0, 1'b1, 2, 1'b0);
        tick_n(1);
        wait_drain("soft_fall_2");

        // Lock delay: a good move restarts it, 15 grounded ticks then force placement
        push(CMD_FALL, 0, 1'b0, 2, 1'b0);
        tick_n(2);
        wait_drain("ground_1");
        soft_drop = 1'b0;
        base = cmds_seen;
        tick_n(14);
        repeat (3) @(negedge Clk);
        check_val("no_lock_14", cmds_seen, base);
        push(CMD_LEFT, 0, 1'b1, 2, 1'b0);
        press(5'b00010);
        wait_drain("left_unground");
        soft_drop = 1'b1;
        push(CMD_FALL, 0, 1'b0, 2, 1'b0);
        tick_n(1);
        wait_drain("ground_2");
        soft_drop = 1'b0;
        base = cmds_seen;
        tick_n(14);
        repeat (3) @(negedge Clk);
        check_val("lock_restarted", cmds_seen, base);

        // Placement with two full rows landing on row 19
        full_left = 2;
        push(CMD_PLACE, 0, 1'b1, 2, 1'b0);
        push(CMD_CLEAR, 19, 1'b1, 2, 1'b0);
        push(CMD_CLEAR, 19, 1'b1, 2, 1'b0);
        push(CMD_SPAWN, 0, 1'b1, 2, 1'b0);
        tick_n(1);
        wait_drain("place_scan");
        check_val("strobe_cycles", strobe_cnt, 1);
        check_val("strobe_lock_lines", strobe_lines, 2);
        check_val("lines_cleared", lines_cleared, 2);
        push(CMD_HOLD, 0, 1'b1, 2, 1'b0);
        press(5'b10000);
        wait_drain("hold_after_spawn");

        // Reset while a clear is outstanding; the late done must not finish the wipe
        soft_drop = 1'b1;
        push(CMD_FALL, 0, 1'b0, 2, 1'b0);
        tick_n(2);
        wait_drain("ground_3");
        soft_drop = 1'b0;
        full_left = 1;
        push(CMD_PLACE, 0, 1'b1, 2, 1'b0);
        push(CMD_CLEAR, 19, 1'b1, 2, 1'b1);
        tick_n(15);
        wait_q_empty("clear_issued");
        repeat (2) @(posedge Clk);
        push(CMD_WIPE, 0, 1'b1, 2, 1'b0);
        full_left = 0;
        #1 RESET = 1'b1;
        @(posedge Clk); #1 RESET = 1'b0;
        @(negedge Clk);
        check_val("rst_cmd_wipe", cmd, CMD_WIPE);
        check_val("rst_mid_valid", cmd_valid, 0);
        check_val("rst_mid_lines", lines_cleared, 0);
        wait_drain("wipe_after_rst");
        repeat (5) @(negedge Clk);
        check_val("logo_after_rst", cmd_valid, 0);
        push(CMD_SPAWN, 0, 1'b1, 2, 1'b0);
        pulse_start();
        wait_drain("spawn_after_rst");
        check_val("strobe_total", strobe_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_flow_sequencer.md
Name: game_flow_sequencer

Overview:
- Parametrised game-flow controller for the falling-block game; successor to the fixed single-purpose gameboard state machine.
- Owns piece lifecycle: wipe, title wait, spawn, input dispatch, gravity, lock delay, placement, multi-row line-clear scan and end of game.
- Issues one encoded command at a time to the gameboard over a valid/done handshake. Sits between keyboard decode / frame timer and the gameboard datapath.

Parameters:
ROWS, 20, board height; scan rows ROWS-1 (bottom) down to 0
GRAVITY_TICKS, 30, frame ticks per automatic fall
SOFT_DROP_TICKS, 2, frame ticks per fall while soft_drop held
LOCK_TICKS, 15, grounded frame ticks before forced placement
HOLD_EN, 1, 0 removes hold support (key_hold ignored)
LINE_W, 16, width of lines_cleared counter

Ports:
Clk  in  1  system clock
RESET  in  1  synchronous, active-high reset
start  in  1  leaves title state
tick  in  1  one-cycle frame tick
key_left, key_right, key_rot_l, key_rot_r, key_hold  in  1 each  one-cycle key pulses
soft_drop  in  1  level, selects SOFT_DROP_TICKS
board_done  in  1  one-cycle completion of current command
board_ok  in  1  valid with board_done: move legal / spawn unblocked
row_full  in  1  combinational answer for scan_row
cmd  out  4  command code (package enum)
cmd_valid  out  1  command pending
scan_row  out  $clog2(ROWS)  row under test / row to clear
lines_cleared  out  LINE_W  total cleared rows, saturating
lock_lines  out  3  rows cleared by last placement, valid with lock_strobe
lock_strobe  out  1  one-cycle pulse when scan completes
game_over  out  1  high in S_END

Behaviour:
- Reset (RESET high at edge): state<=S_WIPE; counters, pending bits, grounded, hold_used, lines_cleared, scan_row, lock_lines cleared; cmd_valid, lock_strobe, game_over 0. Mid-handshake reset abandons the command; a stray board_done afterwards is ignored outside handshake states.
- Handshake: cmd/scan_row driven from registers; cmd_valid held with stable cmd until board_done; the cycle after board_done cmd_valid=0 for at least one cycle. board_ok sampled only with board_done.
- Pending bits: each key pulse sets its pending bit in any state (except S_WIPE/S_LOGO/S_END, where it is dropped); cleared when serviced; re-press while pending is absorbed.
- Gravity: grav_cnt increments on tick in S_IDLE; when grav_cnt >= (soft_drop ? SOFT_DROP_TICKS : GRAVITY_TICKS)-1 on a tick, set fall_pend, grav_cnt<=0. Counter also clears on spawn.
- States:
  S_WIPE: cmd=WIPE; done -> S_LOGO.
  S_LOGO: wait start -> S_LOAD.
  S_LOAD: cmd=SPAWN; done&ok -> S_IDLE; done&!ok -> S_END.
  S_IDLE: pick highest pending, priority hold > rot_r > rot_l > left > right > fall; issue, -> S_ACT. Hold with hold_used=1 or HOLD_EN=0 is dropped silently.
  S_ACT: wait done. Fall & !ok -> grounded=1. Left/right/rotate & ok -> grounded=0, lock_cnt=0. Hold & ok -> hold_used=1, grounded=0. -> S_IDLE.
  Lock: while grounded, lock_cnt increments on tick in S_IDLE; at LOCK_TICKS-1 on tick -> S_PLACE (takes precedence over pending actions that cycle).
  S_PLACE: cmd=PLACE; done -> scan_row=ROWS-1, lock_lines=0, S_SCAN.
  S_SCAN: row_full -> S_CLEAR; else if scan_row==0 -> lock_strobe, S_LOAD (hold_used=0, grounded=0); else scan_row-1.
  S_CLEAR: cmd=CLEAR at scan_row; done -> lock_lines+1 (saturates at 7), lines_cleared+1 (saturates at all-ones), S_SCAN on the same row (rows above shift down).
  S_END: game_over=1; start -> S_WIPE.
- Simultaneous tick that satisfies both gravity and lock in S_IDLE: lock wins, fall_pend cleared.

Decomposition:
- Package game_pkg: cmd_e enum (NONE=0, WIPE, SPAWN, LEFT, RIGHT, ROT_L, ROT_R, FALL, HOLD, PLACE, CLEAR), state_e enum, shared ROWS/COLS defaults.
- Sub-module tick_divider (parametrised period select, clear, expire pulse), instantiated for gravity and lock.

Test Plan:
- Reset then board_done after 3 cycles -> cmd WIPE, S_LOGO; start -> cmd SPAWN; ok=0 -> game_over=1 next cycle.
- Same-cycle key_hold and key_left after spawn -> HOLD issued first, then LEFT; second key_hold before placement -> no HOLD command.
- GRAVITY_TICKS=30, no keys -> FALL issued on 30th tick; soft_drop high -> every 2nd tick.
- FALL returns ok=0, 14 ticks, key_left ok=1 -> lock_cnt reset; 15 further grounded ticks -> PLACE.
- After PLACE, row_full for rows 19 and 18 (19 twice, then not) -> CLEAR row 19 twice, scan to 0, lock_lines=2, lines_cleared=2, lock_strobe one cycle.
- RESET asserted while cmd=CLEAR pending -> next cycle cmd=WIPE, lines_cleared=0, late board_done ignored.
